// File: rtl/gsim_pkg.sv
// -----------------------------------------------------------------------------
// gsim_pkg
// Shared constants and types for the parametrised GSIM Gauss-Seidel solver.
//   - Band coefficients of the system matrix: diagonal 20, |offset| 1..3
//     weights 13, 6, 1 (signs applied in the row datapath).
//   - Fixed-point reciprocal of the diagonal (2^20/20, rounded) and its shift.
//   - Controller state encoding.
// -----------------------------------------------------------------------------
package gsim_pkg;

    localparam int DIAG      = 32'sd20;
    localparam int C1        = 32'sd13;
    localparam int C2        = 32'sd6;
    localparam int C3        = 32'sd1;
    localparam int RECIP     = 32'sd52429;
    localparam int RECIP_SH  = 32'sd20;
    // Half an output LSB at the reciprocal scale: turns the shift into
    // round-half-up.
    localparam int RECIP_RND = 32'sd1 <<< (RECIP_SH - 32'sd1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SOLVE = 2'd2,
        OUT   = 2'd3
    } gsim_state_e;

endpackage

// File: rtl/gsim_param_if.sv
// -----------------------------------------------------------------------------
// gsim_param_if
// Job interface of the GSIM solver.
//   master (job source / result sink): drives in_en, b_in, iter_num
//   slave  (solver): drives in_ready, busy, out_valid, x_out, iters_done
// Widths must match the parameters of the attached gsim_param instance.
// -----------------------------------------------------------------------------
interface gsim_param_if #(
    parameter int B_W  = 16,
    parameter int X_W  = 32,
    parameter int IT_W = 10
) ();

    logic                   in_en;
    logic signed [B_W-1:0]  b_in;
    logic        [IT_W-1:0] iter_num;
    logic                   in_ready;
    logic                   busy;
    logic                   out_valid;
    logic signed [X_W-1:0]  x_out;
    logic        [IT_W-1:0] iters_done;

    modport master (
        output in_en, b_in, iter_num,
        input  in_ready, busy, out_valid, x_out, iters_done
    );

    modport slave (
        input  in_en, b_in, iter_num,
        output in_ready, busy, out_valid, x_out, iters_done
    );

endinterface

// File: rtl/gsim_row_upd.sv
// -----------------------------------------------------------------------------
// gsim_row_upd
// Combinational Gauss-Seidel row update:
//   s     = (b_i << FRAC) + 13(x[i-1]+x[i+1]) - 6(x[i-2]+x[i+2]) + (x[i-3]+x[i+3])
//   x_new = sat((s * RECIP + 2^19) >>> 20)
// Ports:
//   b_i    in  right-hand-side element of this row (signed integer)
//   xm[k]  in  x[i-1-k], used only when vm[k] is set
//   xp[k]  in  x[i+1+k], used only when vp[k] is set
//   x_new  out updated x[i], saturated to the signed X_W range
// -----------------------------------------------------------------------------
module gsim_row_upd
    import gsim_pkg::*;
#(
    parameter int B_W  = 16,
    parameter int X_W  = 32,
    parameter int FRAC = 16
) (
    input  logic signed [B_W-1:0] b_i,
    input  logic signed [X_W-1:0] xm [3],
    input  logic signed [X_W-1:0] xp [3],
    input  logic        [2:0]     vm,
    input  logic        [2:0]     vp,
    output logic signed [X_W-1:0] x_new
);

    localparam int AW = X_W + 6;          // weighted-sum accumulator
    localparam int PW = AW + 18;          // sum times 17-bit reciprocal
    localparam int QW = PW - RECIP_SH;    // quotient before saturation

    logic signed [AW-1:0] pair_s [3];
    logic signed [AW-1:0] sum_s;
    logic signed [PW-1:0] prod_s;
    logic        [QW-1:0] q_s;
    logic        [QW-X_W:0] top_s;

    // Masked symmetric neighbour pairs; terms past either end are zero.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            pair_s[k] = (vm[k] ? AW'(xm[k]) : {AW{1'b0}})
                      + (vp[k] ? AW'(xp[k]) : {AW{1'b0}});
        end
    end

    // Weighted sum, reciprocal multiply with rounding, then saturation.
    always_comb begin
        sum_s  = (AW'(b_i) <<< FRAC)
               + AW'(C1) * pair_s[0]
               - AW'(C2) * pair_s[1]
               + AW'(C3) * pair_s[2];
        prod_s = PW'(sum_s) * PW'(RECIP) + PW'(RECIP_RND);
        q_s    = prod_s[PW-1:RECIP_SH];
        // The quotient fits when every bit above the X_W sign bit matches it.
        top_s  = q_s[QW-1:X_W-1];
        if ((&top_s) || (~|top_s)) begin
            x_new = q_s[X_W-1:0];
        end else if (q_s[QW-1]) begin
            x_new = {1'b1, {(X_W-1){1'b0}}};
        end else begin
            x_new = {1'b0, {(X_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/gsim_param.sv
// -----------------------------------------------------------------------------
// gsim_param
// Parametrised Gauss-Seidel solver for the GSIM banded system. Loads N signed
// right-hand-side values, runs the selected number of in-place sweeps (one
// row per cycle), then streams out the N Q(X_W-FRAC).FRAC solution values.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (aborts any job)
//   bus    gsim_param_if.slave: in_en/b_in/iter_num in, in_ready/busy/
//          out_valid/x_out/iters_done out (all outputs registered)
// Optional feature: define GSIM_EARLY_STOP_EN to end the solve once a whole
// sweep changes no x by TOL LSBs or more (adds parameter TOL).
// -----------------------------------------------------------------------------
module gsim_param
    import gsim_pkg::*;
#(
    parameter int N    = 16,
    parameter int B_W  = 16,
    parameter int X_W  = 32,
    parameter int FRAC = 16,
    parameter int IT_W = 10,
    parameter int ITER = 256
`ifdef GSIM_EARLY_STOP_EN
    ,
    parameter int TOL  = 1
`endif
) (
    input  logic        clk,
    input  logic        reset,
    gsim_param_if.slave bus
);

    localparam int CW = $clog2(N);
    localparam int IW = $clog2(N + 1);
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [IW-1:0] DONE = IW'(N);

    gsim_state_e            state_r, state_s;
    logic [IW-1:0]          idx_r, idx_s;       // load / row / output index
    logic [IT_W-1:0]        cnt_r, cnt_s;       // effective sweep count
    logic [IT_W-1:0]        iters_r, iters_s;
    logic                   in_ready_r, in_ready_s;
    logic                   busy_r, busy_s;
    logic                   out_valid_r, out_valid_s;
    logic signed [X_W-1:0]  x_out_r, x_out_s;
    logic signed [B_W-1:0]  b_r [N];
    logic signed [X_W-1:0]  x_r [N];
    logic                   b_we_s, x_clr_s, x_we_s, accept_s, early_s;
    logic [CW-1:0]          b_idx_s, row_s;
    logic signed [X_W-1:0]  nb_m_s [3];
    logic signed [X_W-1:0]  nb_p_s [3];
    logic [2:0]             vm_s, vp_s;
    logic signed [X_W-1:0]  x_new_s, x_cur_s;

    assign row_s   = idx_r[CW-1:0];
    assign x_cur_s = x_r[row_s];

    // Gather the six neighbours of the current row with end-of-band masks.
    always_comb begin
        vm_s = 3'b000;
        vp_s = 3'b000;
        for (int k = 0; k < 3; k++) begin
            nb_m_s[k] = {X_W{1'b0}};
            nb_p_s[k] = {X_W{1'b0}};
            if (idx_r >= IW'(k + 1)) begin
                vm_s[k]   = 1'b1;
                nb_m_s[k] = x_r[CW'(idx_r - IW'(k + 1))];
            end else begin
                vm_s[k]   = 1'b0;
            end
            // One spare bit so the look-ahead cannot wrap past N-1.
            if (({1'b0, idx_r} + (IW+1)'(k + 1)) <= {1'b0, LAST}) begin
                vp_s[k]   = 1'b1;
                nb_p_s[k] = x_r[CW'(idx_r + IW'(k + 1))];
            end else begin
                vp_s[k]   = 1'b0;
            end
        end
    end

    gsim_row_upd #(
        .B_W  (B_W),
        .X_W  (X_W),
        .FRAC (FRAC)
    ) u_row (
        .b_i   (b_r[row_s]),
        .xm    (nb_m_s),
        .xp    (nb_p_s),
        .vm    (vm_s),
        .vp    (vp_s),
        .x_new (x_new_s)
    );

`ifdef GSIM_EARLY_STOP_EN
    logic [X_W:0] diff_s, absd_s, dcur_s, dmax_r, dmax_s;

    // Running maximum of |x_new - x_old| over the current sweep.
    always_comb begin
        diff_s  = {x_new_s[X_W-1], x_new_s} - {x_cur_s[X_W-1], x_cur_s};
        if (diff_s[X_W]) begin
            absd_s = -diff_s;
        end else begin
            absd_s = diff_s;
        end
        if (absd_s > dmax_r) begin
            dcur_s = absd_s;
        end else begin
            dcur_s = dmax_r;
        end
        early_s = (state_r == SOLVE) && (idx_r == LAST) && (dcur_s < (X_W+1)'(TOL));
        if (state_r == SOLVE) begin
            dmax_s = (idx_r == LAST) ? {(X_W+1){1'b0}} : dcur_s;
        end else begin
            dmax_s = {(X_W+1){1'b0}};
        end
    end

    // Sweep delta register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dmax_r <= {(X_W+1){1'b0}};
        end else begin
            dmax_r <= dmax_s;
        end
    end
`else
    assign early_s = 1'b0;
`endif

    // Next-state and next-output logic of the job controller.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        cnt_s       = cnt_r;
        iters_s     = iters_r;
        out_valid_s = 1'b0;
        x_out_s     = {X_W{1'b0}};
        b_we_s      = 1'b0;
        b_idx_s     = row_s;
        x_clr_s     = 1'b0;
        x_we_s      = 1'b0;
        accept_s    = bus.in_en && in_ready_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    b_we_s  = 1'b1;
                    b_idx_s = {CW{1'b0}};
                    x_clr_s = 1'b1;
                    cnt_s   = (bus.iter_num == {IT_W{1'b0}}) ? IT_W'(ITER) : bus.iter_num;
                    iters_s = {IT_W{1'b0}};
                    idx_s   = IW'(1);
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (accept_s) begin
                    b_we_s = 1'b1;
                    if (idx_r == LAST) begin
                        idx_s   = {IW{1'b0}};
                        state_s = SOLVE;
                    end else begin
                        idx_s = idx_r + IW'(1);
                    end
                end else begin
                    state_s = LOAD;
                end
            end
            SOLVE: begin
                x_we_s = 1'b1;
                if (idx_r == LAST) begin
                    iters_s = iters_r + IT_W'(1);
                    idx_s   = {IW{1'b0}};
                    if ((iters_s == cnt_r) || early_s) begin
                        state_s = OUT;
                    end else begin
                        state_s = SOLVE;
                    end
                end else begin
                    idx_s = idx_r + IW'(1);
                end
            end
            OUT: begin
                // Index N is the drain step that drops out_valid.
                if (idx_r == DONE) begin
                    idx_s   = {IW{1'b0}};
                    state_s = IDLE;
                end else begin
                    out_valid_s = 1'b1;
                    x_out_s     = x_cur_s;
                    idx_s       = idx_r + IW'(1);
                end
            end
            default: begin
                idx_s   = {IW{1'b0}};
                state_s = IDLE;
            end
        endcase
        in_ready_s = (state_s == IDLE) || (state_s == LOAD);
        busy_s     = (state_s == SOLVE) || (state_s == OUT);
    end

    // Controller state, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            idx_r       <= {IW{1'b0}};
            cnt_r       <= {IT_W{1'b0}};
            iters_r     <= {IT_W{1'b0}};
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            x_out_r     <= {X_W{1'b0}};
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            cnt_r       <= cnt_s;
            iters_r     <= iters_s;
            in_ready_r  <= in_ready_s;
            busy_r      <= busy_s;
            out_valid_r <= out_valid_s;
            x_out_r     <= x_out_s;
        end
    end

    // Right-hand-side and in-place solution storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                b_r[i] <= {B_W{1'b0}};
                x_r[i] <= {X_W{1'b0}};
            end
        end else begin
            if (b_we_s) begin
                b_r[b_idx_s] <= bus.b_in;
            end
            if (x_clr_s) begin
                for (int i = 0; i < N; i++) begin
                    x_r[i] <= {X_W{1'b0}};
                end
            end else if (x_we_s) begin
                x_r[row_s] <= x_new_s;
            end
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.busy       = busy_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.x_out      = x_out_r;
    assign bus.iters_done = iters_r;

endmodule

// File: tb/tb_gsim_param.sv
// -----------------------------------------------------------------------------
// tb_gsim_param
// Scoreboard bench for gsim_param: each job pushes its expected x values into
// a queue; a negedge monitor pops one entry per out_valid beat and compares.
// -----------------------------------------------------------------------------
module tb_gsim_param;

    localparam int N = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    gsim_param_if #(.B_W(16), .X_W(32), .IT_W(10)) bus ();

    gsim_param #(
        .N(N), .B_W(16), .X_W(32), .FRAC(16), .IT_W(10), .ITER(256)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] val;
        bit          chk;
    } exp_t;

    exp_t               exp_q [$];
    exp_t               mon_e;
    int                 errors    = 0;
    int                 checks    = 0;
    int                 cyc       = 0;
    int                 nout      = 0;
    int                 first_cyc = 0;
    int                 acc_cyc   = 0;
    logic [31:0]        outs [N];
    logic signed [15:0] bv [N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: one scoreboard entry per output beat.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.out_valid === 1'b1) begin
            if (nout == 0) first_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got x_out=%h with empty scoreboard", bus.x_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.chk) check($sformatf("x_out[%0d]", nout), bus.x_out, mon_e.val);
            end
            if (nout < N) outs[nout] = bus.x_out;
            nout++;
            check("in_ready_during_out", {31'd0, bus.in_ready}, 32'd0);
        end
    end

    // Push 16 expectations: v0 at i0, v1 at i1, zero elsewhere (checked if rest_chk).
    task automatic push_exp(input logic [31:0] v0, input int i0,
                            input logic [31:0] v1, input int i1, input bit rest_chk);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            if (i == i0) begin e.val = v0; e.chk = 1'b1; end
            else if (i == i1) begin e.val = v1; e.chk = 1'b1; end
            else begin e.val = 32'd0; e.chk = rest_chk; end
            exp_q.push_back(e);
        end
    endtask

    task automatic set_bv(input int idx, input logic signed [15:0] v);
        for (int i = 0; i < N; i++) bv[i] = 16'sd0;
        if (idx >= 0) bv[idx] = v;
    endtask

    // Load bv; iter_num is only meaningful on the first beat, junk afterwards.
    task automatic load_job(input logic [9:0] it, input bit gaps);
        int k = 0;
        int guard = 0;
        nout = 0;
        while (k < N && guard < 200) begin
            @(negedge clk);
            if (gaps && (guard % 2 == 1)) begin
                bus.in_en = 1'b0;
            end else begin
                bus.in_en    = 1'b1;
                bus.b_in     = bv[k];
                bus.iter_num = (k == 0) ? it : 10'd7;
                if (bus.in_ready === 1'b1) begin
                    k++;
                    acc_cyc = cyc + 1;
                end
            end
            guard++;
        end
        @(negedge clk);
        bus.in_en = 1'b0;
    endtask

    task automatic pulses_in_solve();
        for (int p = 0; p < 5; p++) begin
            bus.in_en = 1'b1;
            bus.b_in  = 16'sh1234;
            check("in_ready_in_solve", {31'd0, bus.in_ready}, 32'd0);
            check("busy_in_solve", {31'd0, bus.busy}, 32'd1);
            @(negedge clk);
        end
        bus.in_en = 1'b0;
    endtask

    task automatic wait_job(input int sweeps, input logic [9:0] iters_exp);
        int budget = sweeps * N + 60;
        while (nout < N && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("output_count", 32'(nout), 32'(N));
        @(negedge clk);
        check("out_valid_after", {31'd0, bus.out_valid}, 32'd0);
        check("in_ready_after", {31'd0, bus.in_ready}, 32'd1);
        check("busy_after", {31'd0, bus.busy}, 32'd0);
        check("iters_done", {22'd0, bus.iters_done}, {22'd0, iters_exp});
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic real coef(input int d);
        case (d)
            0: coef = 20.0;
            1: coef = -13.0;
            2: coef = 6.0;
            3: coef = -1.0;
            default: coef = 0.0;
        endcase
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_x_out"}, bus.x_out, 32'd0);
        check({tag, "_iters_done"}, {22'd0, bus.iters_done}, 32'd0);
    endtask

    initial begin
        real xr [N];
        real r, rss;
        reset        = 1'b0;
        bus.in_en    = 1'b0;
        bus.b_in     = 16'sd0;
        bus.iter_num = 10'd0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        // All zero, 3 sweeps: latency 3*16+1.
        set_bv(-1, 16'sd0);
        push_exp(32'd0, -1, 32'd0, -1, 1'b1);
        load_job(10'd3, 1'b0);
        wait_job(3, 10'd3);
        check("latency_zero_job", 32'(first_cyc - acc_cyc), 32'd49);

        // b0 = 20, one sweep.
        set_bv(0, 16'sd20);
        push_exp(32'h0001_0000, 0, 32'h0000_A667, 1, 1'b0);
        load_job(10'd1, 1'b0);
        wait_job(1, 10'd1);

        // b0 = -32768: sign extension.
        set_bv(0, -16'sd32768);
        push_exp(32'hF999_9800, 0, 32'd0, -1, 1'b0);
        load_job(10'd1, 1'b0);
        wait_job(1, 10'd1);

        // Gapped load of the b0 = 20 job with ignored pulses during SOLVE.
        set_bv(0, 16'sd20);
        push_exp(32'h0001_0000, 0, 32'h0000_A667, 1, 1'b0);
        load_job(10'd1, 1'b1);
        pulses_in_solve();
        wait_job(1, 10'd1);

        // Gapped load, b15 = 20: only the last row sees a nonzero sum.
        set_bv(15, 16'sd20);
        push_exp(32'h0001_0000, 15, 32'd0, -1, 1'b1);
        load_job(10'd1, 1'b1);
        wait_job(1, 10'd1);

        // Mixed pattern with iter_num = 0 (256 sweeps): residual check.
        bv = '{16'sd3, -16'sd2, 16'sd5, 16'sd1, -16'sd4, 16'sd0, 16'sd2, -16'sd5,
               16'sd4, -16'sd1, 16'sd3, -16'sd3, 16'sd1, 16'sd2, -16'sd2, 16'sd5};
        push_exp(32'd0, -1, 32'd0, -1, 1'b0);
        load_job(10'd0, 1'b0);
        wait_job(256, 10'd256);
        for (int i = 0; i < N; i++) xr[i] = $itor($signed(outs[i])) / 65536.0;
        rss = 0.0;
        for (int i = 0; i < N; i++) begin
            r = $itor(bv[i]);
            for (int j = i - 3; j <= i + 3; j++) begin
                if (j >= 0 && j < N) r = r - coef((i > j) ? i - j : j - i) * xr[j];
            end
            rss = rss + r * r;
        end
        checks++;
        if (!(rss < 1.0e-4)) begin
            errors++;
            $display("FAIL residual: got rss=%g, required < 1e-4", rss);
        end

        // Reset in the middle of SOLVE aborts the job without output.
        set_bv(-1, 16'sd0);
        load_job(10'd3, 1'b0);
        repeat (20) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_idle_outputs("abort");
        @(negedge clk);
        reset = 1'b1;
        check("abort_no_output", 32'(nout), 32'd0);
        @(negedge clk);
        push_exp(32'd0, -1, 32'd0, -1, 1'b1);
        load_job(10'd3, 1'b0);
        wait_job(3, 10'd3);
        check("latency_after_abort", 32'(first_cyc - acc_cyc), 32'd49);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/gsim_param.md
Name: gsim_param

Overview:
- Parametrised Gauss-Seidel solver for the symmetric banded system used by the GSIM family.
- Every row has diagonal 20, neighbours ±1 = -13, ±2 = 6, ±3 = -1. Off-band terms and terms past either end are 0.
- Streams in N signed right-hand-side values b, runs a runtime-selectable number of in-place sweeps, then streams out N fixed-point x values.
- Successor to the fixed 16-unknown GSIM: N, widths and iteration count are configurable, and an input-ready handshake is added.

Parameters:
- N, 16, number of unknowns (≥4).
- B_W, 16, b_in width, signed integer.
- X_W, 32, x_out width, signed Q(X_W-FRAC).FRAC.
- FRAC, 16, fractional bits of x.
- IT_W, 10, iteration-count width.
- ITER, 256, default sweep count used when iter_num==0.
- TOL, 1, early-stop threshold in x LSBs (used only with GSIM_EARLY_STOP_EN).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_en  in  1  b_in valid.
- b_in  in  B_W  signed right-hand-side element.
- iter_num  in  IT_W  sweep count, sampled with the first accepted b; 0 selects ITER.
- in_ready  out  1  block accepts b_in.
- busy  out  1  high in SOLVE and OUT.
- out_valid  out  1  x_out valid.
- x_out  out  X_W  solution element, index order 0..N-1.
- iters_done  out  IT_W  sweeps executed for the current or last job.

Behaviour:
- Reset (reset==0, async): state IDLE, in_ready=1, busy=0, out_valid=0, x_out=0, iters_done=0, all counters 0. Reset mid-job aborts the job; no partial output is produced.
- States: IDLE -> LOAD -> SOLVE -> OUT -> IDLE.
- IDLE/LOAD: in_ready=1. A b_in is accepted when in_en && in_ready.
  - First accepted b: move to LOAD, store b[0], latch iter_num, clear all x to 0.
  - Gaps (in_en low) are allowed and do not advance the index.
  - After the N-th accept, go to SOLVE on the next edge.
  - in_en while in_ready==0 is ignored.
- SOLVE: updates one row per cycle, i = 0..N-1, in place, so x[i] uses x[i-3..i-1] already updated this sweep.
  - s = (b_i<<FRAC) + 13(x[i-1]+x[i+1]) - 6(x[i-2]+x[i+2]) + (x[i-3]+x[i+3]).
  - Accumulator width is X_W+6.
  - x_new = (s*RECIP + 2^19) >>> 20, with RECIP = 52429 (≈2^20/20). Arithmetic shift; this is round-half-up.
  - x_new saturates to the signed X_W range.
  - After row N-1, iters_done increments. When iters_done equals the effective count, go to OUT.
  - SOLVE length is exactly count×N cycles.
- OUT: out_valid=1 for exactly N consecutive cycles, with x_out = x[0]..x[N-1]. Then IDLE, out_valid=0, x_out=0.
  - iters_done holds its value until the next job's first accept.
- End to end: first out_valid arrives count×N+1 cycles after the N-th accept.

Optional Feature:
- Macro GSIM_EARLY_STOP_EN.
- Defined:
  - During each sweep, track d = max |x_new - x_old|.
  - At the end of a sweep, if d < TOL, enter OUT early; iters_done shows the sweeps actually run.
  - The configured count remains the upper bound.
- Undefined: no delta logic; sweep count is always exact.

Decomposition:
- Package gsim_pkg holds:
  - coefficient constants DIAG=20, C1=13, C2=6, C3=1;
  - RECIP=52429 and RECIP_SH=20;
  - the state enum {IDLE, LOAD, SOLVE, OUT}.
- Sub-module gsim_row_upd: combinational row datapath covering the weighted sum, reciprocal multiply, round and saturate. Its inputs are b_i, the six neighbours and boundary-valid masks.
- Top level holds the FSM, counters and the x/b register arrays.

Test Plan:
- All b=0, iter_num=3: out_valid first asserts 49 cycles after the 16th accept; all 16 x_out=0x00000000; iters_done=3.
- b0=20, others 0, iter_num=1: x_out[0]=0x00010000, x_out[1]=0x0000A667.
- b0=-32768 (0x8000), others 0, iter_num=1: x_out[0]=0xF9999800, confirming sign extension.
- Contest 16-value pattern, iter_num=0 (ITER):
  - x[0] within ±0.01 of 3357.0527 and x[8] within ±0.01 of -5725.0258;
  - residual sum of squares <1e-4.
- Handshake: in_en toggled 1-0-1 across the load, then 5 extra in_en pulses during SOLVE: those pulses are ignored; results match the contiguous-load run; in_ready=0 throughout SOLVE/OUT.
- Reset asserted mid-SOLVE: all outputs 0 immediately. After release, a new all-zero job completes normally.
